ring_decoder_8bit: RTL and testbench
====================================

Name: ring_decoder_8bit

Overview:
Receive-side companion to the 8-bit one-hot ring counter. Samples a ring pattern and decodes it to a binary index. Checks that each sample is a legal one-hot code and the correct rotation of the previous sample. Provides lock status, sequence-error pulses and a saturating error count for monitoring.

Parameters:
WIDTH, 8, ring width in bits.
IDX_W, 3, index width; equals log2(WIDTH).
LOCK_CNT, 4, consecutive correct rotations required to declare lock (>=1).
ERR_W, 8, error counter width.
DIR, 0, expected rotation: 0 = left (bit i moves to bit i+1, bit WIDTH-1 wraps to bit 0); 1 = right.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
en  input  1  sample enable; ring_in is sampled on the rising clk edge when en=1.
ring_in  input  WIDTH  ring pattern from the counter.
clr_err  input  1  synchronous clear of err_cnt.
idx  output  IDX_W  binary position of the set bit in the last legal sample.
onehot_ok  output  1  last sample had exactly one bit set.
locked  output  1  high while the FSM is in LOCKED.
seq_err  output  1  one-cycle pulse on an error detected while LOCKED.
wrap  output  1  one-cycle pulse on a correct rotation from position WIDTH-1 to 0 (DIR=0), or from 0 to WIDTH-1 (DIR=1).
err_cnt  output  ERR_W  saturating count of seq_err events.

Behaviour:
- Reset (rst=0, asynchronous): FSM = HUNT; idx, prev, good_cnt, err_cnt = 0; onehot_ok, locked, seq_err, wrap = 0.
- All outputs are registered. A sample taken at edge N is reflected on the outputs after edge N, with one cycle of latency.
- en=0: all state holds; seq_err and wrap are forced to 0; clr_err is still honoured.
- legal = popcount(ring_in)==1. expected = prev rotated per DIR. match = legal && ring_in==expected. A stalled counter (same value twice) is a mismatch.
- idx and prev update only on legal samples; otherwise they hold. onehot_ok updates on every enabled sample.
- FSM states, evaluated on enabled samples:
  - HUNT:
    - legal -> TRACK; prev=ring_in; good_cnt=0.
    - illegal -> stay in HUNT.
    - No errors are counted in HUNT.
  - TRACK:
    - match -> good_cnt+1; when good_cnt+1==LOCK_CNT, go to LOCKED and clear good_cnt.
    - legal but not match -> stay in TRACK; good_cnt=0; prev=ring_in.
    - illegal -> HUNT.
    - No errors are counted in TRACK.
  - LOCKED:
    - match -> stay in LOCKED.
    - legal mismatch -> seq_err=1; err_cnt++; go to TRACK with good_cnt=0 and prev=ring_in.
    - illegal -> seq_err=1; err_cnt++; go to HUNT.
- locked mirrors the state: it falls after the same edge that raises seq_err.
- wrap is asserted only on a match (in TRACK or LOCKED) whose transition is the wrap position.
- err_cnt saturates at 2^ERR_W-1. clr_err=1 forces err_cnt to 0 at the next edge; it wins over a simultaneous increment.
- Reset mid-operation: immediate return to the reset values listed above; lock must be re-acquired from HUNT.

Test Plan:
1. Reset, then drive 00000001 and rotate left each cycle with en=1 -> onehot_ok=1 after the first edge; locked=1 after the 5th sample (1 plus LOCK_CNT matches); idx tracks 0,1,2,...
2. Locked, rotate 10000000 -> 00000001 -> wrap=1 for exactly one cycle with idx=0; no wrap pulse during HUNT.
3. Locked, inject 00000101 -> seq_err=1 for one cycle; err_cnt=1; locked=0; onehot_ok=0; idx holds its prior value; FSM goes to HUNT.
4. Locked at 00000100, drive 00010000 (skip) -> seq_err=1; err_cnt increments; FSM goes to TRACK; re-lock after 4 further correct rotations.
5. Hold en=0 for 10 cycles mid-sequence, then resume with the next pattern -> no state change and no errors; locked stays 1.
6. Force 255 errors, then a 256th -> err_cnt holds at 255. Assert clr_err together with an error -> err_cnt=0. Assert rst=0 between edges -> outputs go to reset values immediately.

Source files
------------

// File: rtl/ring_decoder_8bit.sv
// Receive-side checker for a one-hot ring counter: decodes the active position, tracks
// rotation lock and counts sequence errors seen while locked.
module ring_decoder_8bit #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned IDX_W    = 3,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned ERR_W    = 8,
   parameter bit          DIR      = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] ring_in,
   input  logic             clr_err,
   output logic [IDX_W-1:0] idx,
   output logic             onehot_ok,
   output logic             locked,
   output logic             seq_err,
   output logic             wrap,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned GcW = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {StHunt, StTrack, StLocked} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   prev_q, prev_d;
   logic [GcW-1:0]     good_q, good_d, good_inc;
   logic [IDX_W-1:0]   idx_q, idx_d, enc;
   logic               ok_q, ok_d;
   logic               locked_q, locked_d;
   logic               seq_err_q, seq_err_d;
   logic               wrap_q, wrap_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               legal, match, at_wrap, err_hit;
   logic [WIDTH-1:0]   expected;

   // Pattern classification against the previous legal sample.
   always_comb begin
      legal    = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
      expected = DIR ? {prev_q[0], prev_q[WIDTH-1:1]} : {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
      match    = legal && (ring_in == expected);
      at_wrap  = DIR ? prev_q[0] : prev_q[WIDTH-1];
      good_inc = good_q + GcW'(1);
      enc      = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (ring_in[i]) enc = IDX_W'(i);
      end
   end

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      good_d    = good_q;
      idx_d     = idx_q;
      ok_d      = ok_q;
      seq_err_d = 1'b0;
      wrap_d    = 1'b0;
      err_hit   = 1'b0;

      if (en) begin
         ok_d = legal;
         if (legal) begin
            prev_d = ring_in;
            idx_d  = enc;
         end
         unique case (state_q)
            StHunt: begin
               if (legal) begin
                  state_d = StTrack;
                  good_d  = '0;
               end
            end
            StTrack: begin
               if (match) begin
                  wrap_d = at_wrap;
                  if (good_inc == GcW'(LOCK_CNT)) begin
                     state_d = StLocked;
                     good_d  = '0;
                  end else begin
                     good_d = good_inc;
                  end
               end else if (legal) begin
                  good_d = '0;
               end else begin
                  state_d = StHunt;
                  good_d  = '0;
               end
            end
            StLocked: begin
               if (match) begin
                  wrap_d = at_wrap;
               end else begin
                  seq_err_d = 1'b1;
                  err_hit   = 1'b1;
                  good_d    = '0;
                  state_d   = legal ? StTrack : StHunt;
               end
            end
            default: state_d = StHunt;
         endcase
      end

      locked_d = (state_d == StLocked);

      // Clear takes priority over a same-cycle error.
      if (clr_err) begin
         err_d = '0;
      end else if (err_hit && (err_q != '1)) begin
         err_d = err_q + ERR_W'(1);
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StHunt;
         prev_q    <= '0;
         good_q    <= '0;
         idx_q     <= '0;
         ok_q      <= 1'b0;
         locked_q  <= 1'b0;
         seq_err_q <= 1'b0;
         wrap_q    <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         good_q    <= good_d;
         idx_q     <= idx_d;
         ok_q      <= ok_d;
         locked_q  <= locked_d;
         seq_err_q <= seq_err_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
      end
   end

   assign idx       = idx_q;
   assign onehot_ok = ok_q;
   assign locked    = locked_q;
   assign seq_err   = seq_err_q;
   assign wrap      = wrap_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_ring_decoder_8bit.sv
// Directed bench for ring_decoder_8bit (WIDTH=8, LOCK_CNT=4, DIR=left).
module tb_ring_decoder_8bit;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] ring_in;
   logic       clr_err;
   logic [2:0] idx;
   logic       onehot_ok;
   logic       locked;
   logic       seq_err;
   logic       wrap;
   logic [7:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   ring_decoder_8bit dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ring_in  (ring_in),
      .clr_err  (clr_err),
      .idx      (idx),
      .onehot_ok(onehot_ok),
      .locked   (locked),
      .seq_err  (seq_err),
      .wrap     (wrap),
      .err_cnt  (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [2:0] e_idx, input logic e_ok,
                             input logic e_lock, input logic e_seq, input logic e_wrap,
                             input logic [7:0] e_err);
      check({tag, ".idx"}, 32'(idx), 32'(e_idx));
      check({tag, ".onehot_ok"}, 32'(onehot_ok), 32'(e_ok));
      check({tag, ".locked"}, 32'(locked), 32'(e_lock));
      check({tag, ".seq_err"}, 32'(seq_err), 32'(e_seq));
      check({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
      check({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_err));
   endtask

   // Apply one enabled sample; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic [7:0] pat);
      en      = 1'b1;
      ring_in = pat;
      @(posedge clk);
      #1;
   endtask

   // From HUNT or TRACK: 01 then four correct left rotations ends LOCKED at 0x10.
   task automatic get_locked();
      step(8'h01);
      step(8'h02);
      step(8'h04);
      step(8'h08);
      step(8'h10);
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b0;
      ring_in = 8'h00;
      clr_err = 1'b0;
      #2 rst = 1'b0;
      #1 expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Acquire lock: locked only after the 5th sample.
      for (int i = 0; i < 8; i++) begin
         step(8'(1 << i));
         expect_out($sformatf("acq%0d", i), 3'(i), 1'b1, (i >= 4), 1'b0, 1'b0, 8'd0);
      end
      step(8'h01);
      expect_out("wrap", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
      step(8'h02);
      expect_out("post_wrap", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

      // Illegal pattern while locked.
      step(8'h05);
      expect_out("illegal", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
      step(8'h04);
      expect_out("hunt_exit", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
      step(8'h08);
      step(8'h10);
      step(8'h20);
      expect_out("relock3", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
      step(8'h40);
      expect_out("relock4", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
      step(8'h80);
      step(8'h01);
      step(8'h02);
      step(8'h04);

      // Skipped position while locked at 0x04.
      step(8'h10);
      expect_out("skip", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
      step(8'h20);
      step(8'h40);
      step(8'h80);
      expect_out("skip_track", 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
      step(8'h01);
      expect_out("skip_relock", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2);

      // Enable low with garbage on the input.
      en      = 1'b0;
      ring_in = 8'hff;
      repeat (10) @(posedge clk);
      #1 expect_out("en_low", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
      step(8'h02);
      expect_out("resume", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);

      // No wrap pulse when the wrap transition happens from HUNT.
      step(8'h00);
      expect_out("zero", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
      step(8'h80);
      expect_out("hunt_to_track", 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
      step(8'h00);
      expect_out("track_to_hunt", 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
      step(8'h01);
      expect_out("hunt_nowrap", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);

      // Saturate the error counter.
      for (int i = 0; i < 252; i++) begin
         get_locked();
         step(8'h00);
      end
      expect_out("err255", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
      get_locked();
      step(8'h00);
      expect_out("err_sat", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
      get_locked();
      clr_err = 1'b1;
      step(8'h00);
      clr_err = 1'b0;
      expect_out("clr_wins", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      get_locked();
      step(8'h05);
      expect_out("err_after_clr", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);

      // Asynchronous reset between edges.
      get_locked();
      check("pre_reset.locked", 32'(locked), 32'd1);
      #3 rst = 1'b0;
      #1 expect_out("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      #1 rst = 1'b1;
      step(8'h02);
      step(8'h04);
      step(8'h08);
      step(8'h10);
      expect_out("rst_track", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      step(8'h20);
      expect_out("rst_relock", 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
